// File: rtl/key_uart_pkg.sv
// key_uart_pkg: shared state type, key codes and frame constants for the key-to-UART scheduler.
package key_uart_pkg;
  typedef enum logic [2:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE, NEXT} state_t;
  localparam logic [3:0] KEY_NONE = 4'b1111;
  localparam logic [3:0] KEY_S1 = 4'b0001;
  localparam logic [3:0] KEY_S2 = 4'b0010;
  localparam logic [3:0] KEY_S3 = 4'b0100;
  localparam logic [3:0] KEY_S4 = 4'b1000;
  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam int FRAME_LEN = 3;
  // Returns {valid, index}; only the four one-hot codes are events.
  function automatic logic [2:0] key_decode(input logic [3:0] kv);
    key_decode = (kv == KEY_S1) ? 3'b100 :
                 (kv == KEY_S2) ? 3'b101 :
                 (kv == KEY_S3) ? 3'b110 :
                 (kv == KEY_S4) ? 3'b111 : 3'b000;
  endfunction
endpackage

// File: rtl/key_evt_fifo.sv
// key_evt_fifo: DEPTH-deep FIFO of 2-bit key indices; a push while full is accepted only alongside a pop.
module key_evt_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     key_clk,
  input  logic                     key_rst,
  input  logic                     push,
  input  logic [1:0]               push_data,
  input  logic                     pop,
  output logic [1:0]               pop_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     drop
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] level_q, level_d;
  logic [1:0] mem_q [DEPTH];
  logic [1:0] mem_d [DEPTH];
  logic push_ok, pop_ok;
  always_comb begin
    pop_ok = pop && (level_q != '0);
    push_ok = push && ((level_q != FULL) || pop_ok);
    mem_d = mem_q;
    if (push_ok) mem_d[wr_ptr_q] = push_data;
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    level_d = level_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  end
  always_ff @(posedge key_clk or posedge key_rst) begin
    if (key_rst) begin
      mem_q <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q <= level_d;
    end
  end
  assign pop_data = mem_q[rd_ptr_q];
  assign level = level_q;
  assign drop = push && !push_ok;
endmodule

// File: rtl/key_uart_sched.sv
// key_uart_sched: queues debounced key events and sends each as a 3-byte ASCII frame
// over the shared UART using the tx_start/tx_busy handshake with an ack timeout.
module key_uart_sched
  import key_uart_pkg::*;
#(
  parameter int          DEPTH       = 4,
  parameter logic [7:0]  PREFIX      = 8'h4B,
  parameter logic [7:0]  TERM        = 8'h0A,
  parameter int          ACK_TIMEOUT = 16
) (
  input  logic                     key_clk,
  input  logic                     key_rst,
  input  logic [3:0]               key_value,
  input  logic                     tx_busy,
  input  logic                     ovf_clr,
  output logic                     tx_start,
  output logic [7:0]               tx_data,
  output logic                     ovf,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     busy
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [1:0] LAST_BYTE = 2'(FRAME_LEN - 1);
  state_t state_q, state_d;
  logic [1:0] byte_idx_q, byte_idx_d, frame_key_q, frame_key_d, evt_idx, head;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0] tx_data_q, tx_data_d, frame_byte;
  logic tx_start_q, tx_start_d, ovf_q, ovf_d, evt, pop, drop;
  assign {evt, evt_idx} = key_decode(key_value);
  key_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .key_clk   (key_clk),
    .key_rst   (key_rst),
    .push      (evt),
    .push_data (evt_idx),
    .pop       (pop),
    .pop_data  (head),
    .level     (fifo_level),
    .drop      (drop)
  );
  assign frame_byte = (byte_idx_q == 2'd0) ? PREFIX :
                      (byte_idx_q == 2'd1) ? ASCII_0 + 8'd1 + 8'(frame_key_q) : TERM;
  always_comb begin
    state_d = state_q;
    byte_idx_d = byte_idx_q;
    frame_key_d = frame_key_q;
    timer_d = timer_q;
    tx_data_d = tx_data_q;
    tx_start_d = 1'b0;
    pop = 1'b0;
    ovf_d = drop || (ovf_q && !ovf_clr);
    case (state_q)
      IDLE: if (fifo_level != '0 && !tx_busy) begin
        pop = 1'b1;
        frame_key_d = head;
        byte_idx_d = 2'd0;
        state_d = SEND;
      end
      SEND: begin
        tx_data_d = frame_byte;
        tx_start_d = 1'b1;
        timer_d = '0;
        state_d = WAIT_ACK;
      end
      // A missing ack is treated as a sent byte so a dead UART cannot stall the queue.
      WAIT_ACK: if (tx_busy) state_d = WAIT_DONE;
        else if (timer_q == TIMER_LAST) state_d = NEXT;
        else timer_d = timer_q + 1'b1;
      WAIT_DONE: if (!tx_busy) state_d = NEXT;
      NEXT: if (byte_idx_q == LAST_BYTE) state_d = IDLE;
        else begin
          byte_idx_d = byte_idx_q + 2'd1;
          state_d = SEND;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge key_clk or posedge key_rst) begin
    if (key_rst) begin
      state_q <= IDLE;
      byte_idx_q <= '0;
      frame_key_q <= '0;
      timer_q <= '0;
      tx_data_q <= '0;
      tx_start_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      byte_idx_q <= byte_idx_d;
      frame_key_q <= frame_key_d;
      timer_q <= timer_d;
      tx_data_q <= tx_data_d;
      tx_start_q <= tx_start_d;
      ovf_q <= ovf_d;
    end
  end
  assign tx_start = tx_start_q;
  assign tx_data = tx_data_q;
  assign ovf = ovf_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_key_uart_sched.sv
// tb_key_uart_sched: directed and randomized checks of the key-to-UART scheduler against
// an expected byte stream built from queued key events ("K", digit, LF per event).
module tb_key_uart_sched;
  logic key_clk, key_rst, ovf_clr, tx_start, ovf, busy;
  logic [3:0] key_value;
  logic [7:0] tx_data;
  logic [2:0] fifo_level;
  logic tx_busy, uart_busy, hold_busy, never, pend, prev_start;
  int busy_len, ub_cnt, cyc, peak, checks, failures;
  logic [7:0] got[$];
  logic [7:0] exp[$];
  int got_cyc[$];

  key_uart_sched dut (
    .key_clk(key_clk), .key_rst(key_rst), .key_value(key_value), .tx_busy(tx_busy),
    .ovf_clr(ovf_clr), .tx_start(tx_start), .tx_data(tx_data), .ovf(ovf),
    .fifo_level(fifo_level), .busy(busy)
  );

  assign tx_busy = uart_busy | hold_busy;

  initial key_clk = 1'b0;
  always #5 key_clk = ~key_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, req);
    end
  endtask

  // Monitor: records every tx_start byte and its cycle, and tracks the queue peak.
  initial begin
    cyc = 0; peak = 0; prev_start = 1'b0;
    forever begin
      @(posedge key_clk); #1;
      cyc++;
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
      if (tx_start === 1'b1) begin
        got.push_back(tx_data);
        got_cyc.push_back(cyc);
        chk("start_one_cycle", {31'd0, prev_start}, 32'd0);
      end
      prev_start = tx_start;
    end
  end

  // UART model: raises busy one cycle after tx_start, holds it busy_len cycles.
  initial begin
    uart_busy = 1'b0; pend = 1'b0; ub_cnt = 0;
    forever begin
      @(posedge key_clk); #1;
      if (ub_cnt > 0) begin
        ub_cnt--;
        if (ub_cnt == 0) uart_busy = 1'b0;
      end
      if (pend) begin
        pend = 1'b0;
        uart_busy = 1'b1;
        ub_cnt = busy_len;
      end
      if (tx_start === 1'b1 && !never) pend = 1'b1;
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge key_clk); #2;
    end
  endtask

  task automatic pulse(int k);
    key_value = 4'b0001 << k;
    tick();
    key_value = 4'b1111;
  endtask

  function automatic void add_frame(int k);
    string s;
    s = $sformatf("K%0d\n", k + 1);
    for (int i = 0; i < s.len(); i++) exp.push_back(8'(s[i]));
  endfunction

  task automatic wait_bytes(string tag, int n, int lim);
    int k;
    k = 0;
    while (got.size() < n && k < lim) begin
      tick();
      k++;
    end
    chk(tag, got.size(), n);
  endtask

  task automatic wait_idle(string tag, int lim);
    int k;
    k = 0;
    while ((busy !== 1'b0 || tx_busy !== 1'b0 || fifo_level !== 3'd0) && k < lim) begin
      tick();
      k++;
    end
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_level"}, {29'd0, fifo_level}, 32'd0);
  endtask

  task automatic cmp_stream(string tag);
    chk({tag, "_len"}, got.size(), exp.size());
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), {24'd0, got[i]}, {24'd0, exp[i]});
  endtask

  task automatic clear_streams();
    got.delete();
    got_cyc.delete();
    exp.delete();
  endtask

  initial begin
    int c0, n, g, k;
    logic [3:0] junk [5];
    junk = '{4'b1111, 4'b0000, 4'b0011, 4'b0101, 4'b1110};
    checks = 0; failures = 0;
    key_rst = 1'b1; key_value = 4'b1111; ovf_clr = 1'b0; hold_busy = 1'b0;
    never = 1'b0; busy_len = 10;
    tick(3);
    chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_level", {29'd0, fifo_level}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    key_rst = 1'b0;
    tick(2);

    // Single S3 event: latency, frame bytes, return to idle.
    clear_streams();
    pulse(2);
    c0 = cyc;
    add_frame(2);
    chk("s3_level_after_e0", {29'd0, fifo_level}, 32'd1);
    wait_bytes("s3_bytes", 3, 200);
    if (got_cyc.size() > 0) chk("s3_latency", got_cyc[0], c0 + 2);
    wait_idle("s3_idle", 200);
    cmp_stream("s3");
    chk("s3_tx_data_held", {24'd0, tx_data}, 32'h0A);

    // S1,S2,S4 two cycles apart against a slow UART.
    clear_streams();
    busy_len = 50;
    peak = 0;
    pulse(0); tick();
    pulse(1); tick();
    pulse(3);
    add_frame(0); add_frame(1); add_frame(3);
    wait_bytes("seq_bytes", 9, 1500);
    chk("seq_peak", peak, 2);
    wait_idle("seq_idle", 300);
    cmp_stream("seq");

    // Overflow with UART held busy, set-wins clear, push-while-full-with-pop.
    clear_streams();
    busy_len = 3;
    hold_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pulse(i); tick();
      add_frame(i);
    end
    chk("ovf_level_full", {29'd0, fifo_level}, 32'd4);
    chk("ovf_not_yet", {31'd0, ovf}, 32'd0);
    pulse(0); tick();
    pulse(1); tick();
    chk("ovf_set", {31'd0, ovf}, 32'd1);
    chk("ovf_level_kept", {29'd0, fifo_level}, 32'd4);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("ovf_cleared", {31'd0, ovf}, 32'd0);
    key_value = 4'b0100; ovf_clr = 1'b1; tick();
    key_value = 4'b1111; ovf_clr = 1'b0;
    chk("ovf_set_wins", {31'd0, ovf}, 32'd1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("ovf_cleared2", {31'd0, ovf}, 32'd0);
    hold_busy = 1'b0; key_value = 4'b1000; tick(); key_value = 4'b1111;
    add_frame(3);
    chk("full_push_pop_level", {29'd0, fifo_level}, 32'd4);
    chk("full_push_pop_no_ovf", {31'd0, ovf}, 32'd0);
    wait_bytes("ovf_bytes", 15, 1000);
    wait_idle("ovf_idle", 200);
    cmp_stream("ovf");

    // UART never acknowledges: each byte advances on the ack timeout.
    clear_streams();
    never = 1'b1;
    pulse(1);
    add_frame(1);
    wait_bytes("to_bytes", 3, 200);
    if (got_cyc.size() == 3) begin
      chk("to_gap01", got_cyc[1] - got_cyc[0], 18);
      chk("to_gap12", got_cyc[2] - got_cyc[1], 18);
    end
    wait_idle("to_idle", 100);
    cmp_stream("to");
    never = 1'b0;

    // Non-event codes are ignored.
    clear_streams();
    for (int i = 0; i < 5; i++) begin
      key_value = junk[i];
      tick();
    end
    key_value = 4'b1111;
    tick(5);
    chk("junk_level", {29'd0, fifo_level}, 32'd0);
    chk("junk_no_start", got.size(), 0);
    chk("junk_busy", {31'd0, busy}, 32'd0);

    // Randomized bursts with junk codes in the gaps.
    for (int r = 0; r < 8; r++) begin
      clear_streams();
      never = ($urandom_range(0, 3) == 0);
      busy_len = $urandom_range(1, 8);
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        k = $urandom_range(0, 3);
        pulse(k);
        add_frame(k);
        g = $urandom_range(0, 3);
        for (int j = 0; j < g; j++) begin
          key_value = junk[$urandom_range(0, 4)];
          tick();
        end
        key_value = 4'b1111;
      end
      wait_bytes($sformatf("rnd%0d_bytes", r), 3 * n, 200 * n);
      wait_idle($sformatf("rnd%0d_idle", r), 200);
      cmp_stream($sformatf("rnd%0d", r));
    end
    never = 1'b0;

    // Reset during byte1 with two events queued.
    clear_streams();
    busy_len = 20;
    pulse(0); tick();
    pulse(1); tick();
    pulse(2);
    wait_bytes("rst_mid_bytes", 2, 200);
    tick(2);
    chk("rst_mid_level_before", {29'd0, fifo_level}, 32'd2);
    key_rst = 1'b1;
    #1;
    chk("rst_mid_tx_start", {31'd0, tx_start}, 32'd0);
    chk("rst_mid_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_mid_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_mid_level", {29'd0, fifo_level}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    tick(3);
    key_rst = 1'b0;
    tick(100);
    chk("rst_mid_no_more_bytes", got.size(), 2);
    chk("rst_mid_level_after", {29'd0, fifo_level}, 32'd0);
    chk("rst_mid_busy_after", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
